// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment types, constants and the hex-to-segment decoder
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic seg_t hex_to_seg_n(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot counter and digit index, with a snapshot strobe at the start of each frame
module seg7_scan_timer #(
  parameter int SLOT_CYCLES = 12500,
  parameter int N_DIGITS = 8,
  localparam int SW = $clog2(SLOT_CYCLES),
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [SW-1:0] slot_cnt,
  output logic [IW-1:0] idx,
  output logic          snap_en
);
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wrap;
  always_comb begin
    wrap = slot_cnt_q == SW'(SLOT_CYCLES - 1);
    slot_cnt_d = wrap ? '0 : slot_cnt_q + SW'(1);
    idx_d = !wrap ? idx_q : (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q <= idx_d;
    end
  end
  assign slot_cnt = slot_cnt_q;
  assign idx = idx_q;
  assign snap_en = slot_cnt_q == '0 && idx_q == '0;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit 7-segment scanner with per-frame input snapshot, LZ suppression and PWM
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SLOT_CYCLES = 12500,
  parameter int DEAD_CYCLES = 250,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*N_DIGITS-1:0]  digits,
  input  logic [N_DIGITS-1:0]    dp_in,
  input  logic [N_DIGITS-1:0]    blank,
  input  logic                   lz_en,
  input  logic [BRIGHT_BITS-1:0] bright,
  output logic [6:0]             seg_n,
  output logic                   dp_n,
  output logic [N_DIGITS-1:0]    an_n,
  output logic                   frame_start
);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic snap_en;
  seg7_scan_timer #(.SLOT_CYCLES(SLOT_CYCLES), .N_DIGITS(N_DIGITS)) u_timer (
    .clk(clk), .rst(rst), .slot_cnt(slot_cnt), .idx(idx), .snap_en(snap_en)
  );
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0] dp_q, dp_d, blank_q, blank_d, lzmask_q, lzmask_d, lz_live, an_n_q, an_n_d;
  logic [BRIGHT_BITS-1:0] bright_q, bright_d;
  seg_t seg_n_q, seg_n_d;
  logic dp_n_q, dp_n_d, frame_start_q, zero_run, lit, dark;
  logic [31:0] on_len;
  // Outputs use the snapshot's next value so the snapshot cycle itself already sees fresh inputs
  always_comb begin
    lz_live = '0;
    zero_run = lz_en;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && digits[4*i +: 4] == 4'h0;
      lz_live[i] = zero_run;
    end
    digits_d = snap_en ? digits : digits_q;
    dp_d = snap_en ? dp_in : dp_q;
    blank_d = snap_en ? blank : blank_q;
    bright_d = snap_en ? bright : bright_q;
    lzmask_d = snap_en ? lz_live : lzmask_q;
    on_len = (32'(SLOT_CYCLES - DEAD_CYCLES) * (32'(bright_d) + 32'd1)) >> BRIGHT_BITS;
    lit = 32'(slot_cnt) >= 32'(DEAD_CYCLES) && 32'(slot_cnt) < 32'(DEAD_CYCLES) + on_len;
    dark = blank_d[idx] | lzmask_d[idx];
    seg_n_d = dark ? SEG_BLANK : hex_to_seg_n(digits_d[{idx, 2'b00} +: 4]);
    dp_n_d = dark | ~dp_d[idx];
    an_n_d = lit ? ~(N_DIGITS'(1) << idx) : '1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      dp_q <= '0;
      blank_q <= '0;
      bright_q <= '0;
      lzmask_q <= '0;
      seg_n_q <= SEG_BLANK;
      dp_n_q <= 1'b1;
      an_n_q <= '1;
      frame_start_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dp_q <= dp_d;
      blank_q <= blank_d;
      bright_q <= bright_d;
      lzmask_q <= lzmask_d;
      seg_n_q <= seg_n_d;
      dp_n_q <= dp_n_d;
      an_n_q <= an_n_d;
      frame_start_q <= snap_en;
    end
  end
  assign seg_n = seg_n_q;
  assign dp_n = dp_n_q;
  assign an_n = an_n_q;
  assign frame_start = frame_start_q;
endmodule
